// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The FIFO connects through the slave modport; producers and consumers use master.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en, err_clr,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, err_clr,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, registered or fall-through read,
// programmable almost-full/empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
  localparam logic          AF_RST  = (AF_THRESH == 0) ? 1'b1 : 1'b0;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc_c;
  logic                  rd_acc_c;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers, occupancy, flags, error bits and read data.
  always_comb begin
    wr_acc_c = bus.wr_en && !full_q;
    rd_acc_c = bus.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc_c) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_acc_c) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // A new error in the same cycle as err_clr keeps the flag set.
    if (bus.err_clr)            ovf_d = 1'b0;
    if (bus.wr_en && full_q)    ovf_d = 1'b1;
    if (bus.err_clr)            unf_d = 1'b0;
    if (bus.rd_en && empty_q)   unf_d = 1'b1;

    // Fall-through presents the post-edge head; a word written into the head slot
    // this cycle is forwarded from din since it is not yet in memory.
    if (FWFT != 0) begin
      if (count_d == '0)                           dout_d = '0;
      else if (wr_acc_c && (wr_ptr_q == rd_ptr_d)) dout_d = bus.din;
      else                                         dout_d = mem_q[rd_ptr_d];
    end else if (rd_acc_c) begin
      dout_d = mem_q[rd_ptr_q];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= AF_RST;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
